// File: rtl/rtc_display_scan.sv
// rtl/rtc_display_scan.sv - HH.MM.SS six-digit multiplexed 7-segment scanner for RTC time fields
// Glitch-filtered input, frame-synchronous load, registered outputs with anti-ghost blanking.
module rtc_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SUPPRESS_HZ    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       enable,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_en,
    output logic       frame_tick
);

    localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
    localparam logic [6:0]     SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0]     DIG_OFF   = {6{DIG_ACTIVE_LOW}};
    localparam logic [6:0]     SEG_DASH  = 7'h40;
    localparam logic [6:0]     SEG_BLANK = 7'h00;

    logic [16:0]   samp;
    logic [16:0]   stable;
    logic [16:0]   disp;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          en_d;

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = SEG_DASH;
        endcase
        return r;
    endfunction

    // {tens, ones} of a 0..63 value by compare/subtract; >=60 is flagged separately
    function automatic logic [7:0] split60(input logic [5:0] v);
        logic [7:0] r;
        if (v >= 6'd50)      r = {4'd5, 4'(v - 6'd50)};
        else if (v >= 6'd40) r = {4'd4, 4'(v - 6'd40)};
        else if (v >= 6'd30) r = {4'd3, 4'(v - 6'd30)};
        else if (v >= 6'd20) r = {4'd2, 4'(v - 6'd20)};
        else if (v >= 6'd10) r = {4'd1, 4'(v - 6'd10)};
        else                 r = {4'd0, v[3:0]};
        return r;
    endfunction

    function automatic logic [7:0] split24(input logic [4:0] v);
        logic [7:0] r;
        if (v >= 5'd20)      r = {4'd2, 4'(v - 5'd20)};
        else if (v >= 5'd10) r = {4'd1, 4'(v - 5'd10)};
        else                 r = {4'd0, v[3:0]};
        return r;
    endfunction

    logic [5:0] d_sec;
    logic [5:0] d_min;
    logic [4:0] d_hr;
    logic [3:0] s_t, s_o, m_t, m_o, h_t, h_o;
    logic       sec_bad, min_bad, hr_bad;
    logic       hz_blank;
    logic [6:0] slot_code;
    logic       slot_dp;
    logic [5:0] slot_dig;

    assign {d_hr, d_min, d_sec} = disp;

    always_comb begin
        {s_t, s_o} = split60(d_sec);
        {m_t, m_o} = split60(d_min);
        {h_t, h_o} = split24(d_hr);
        sec_bad    = (d_sec > 6'd59);
        min_bad    = (d_min > 6'd59);
        hr_bad     = (d_hr > 5'd23);
    end

    always_comb begin
        slot_code = SEG_BLANK;
        slot_dp   = 1'b0;
        slot_dig  = 6'b000000;
        hz_blank  = 1'b0;
        case (idx)
            3'd0: slot_code = sec_bad ? SEG_DASH : font(s_o);
            3'd1: slot_code = sec_bad ? SEG_DASH : font(s_t);
            3'd2: slot_code = min_bad ? SEG_DASH : font(m_o);
            3'd3: slot_code = min_bad ? SEG_DASH : font(m_t);
            3'd4: slot_code = hr_bad  ? SEG_DASH : font(h_o);
            3'd5: begin
                hz_blank  = SUPPRESS_HZ && (d_hr < 5'd10);
                slot_code = hr_bad ? SEG_DASH : (hz_blank ? SEG_BLANK : font(h_t));
            end
            default: slot_code = SEG_BLANK;
        endcase
        slot_dp = ((idx == 3'd4) || (idx == 3'd2)) && !d_sec[0];
        // digit drive only after the blanking window so the previous digit can discharge
        if ((cnt >= BLANK_END) && !hz_blank && (idx <= 3'd5))
            slot_dig = 6'b000001 << idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp       <= '0;
            stable     <= '0;
            disp       <= '0;
            cnt        <= '0;
            idx        <= '0;
            en_d       <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= SEG_ACTIVE_LOW;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            samp <= {hours, minutes, seconds};
            if ({hours, minutes, seconds} == samp)
                stable <= samp;
            en_d       <= enable;
            frame_tick <= 1'b0;

            if (!enable) begin
                cnt    <= '0;
                idx    <= '0;
                seg    <= SEG_OFF;
                dp     <= SEG_ACTIVE_LOW;
                dig_en <= DIG_OFF;
            end else begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (idx == 3'd5) begin
                        idx        <= 3'd0;
                        disp       <= stable;
                        frame_tick <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end

                // first cycle after enable rises: fresh frame, pins stay dark this cycle
                if (!en_d) begin
                    disp       <= stable;
                    frame_tick <= 1'b1;
                    seg        <= SEG_OFF;
                    dp         <= SEG_ACTIVE_LOW;
                    dig_en     <= DIG_OFF;
                end else begin
                    seg    <= slot_code ^ SEG_OFF;
                    dp     <= slot_dp ^ SEG_ACTIVE_LOW;
                    dig_en <= slot_dig ^ DIG_OFF;
                end
            end
        end
    end

endmodule
